// File: rtl/datamem_pkg.sv
// Shared constants for the parametrised data memory: FSM encodings, access
// encodings and the boot table written after the power-on clear.
package datamem_pkg;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_INIT  = 2'd1;
  localparam logic [1:0] ST_IDLE  = 2'd2;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic SEL_WORD = 1'b1;
  localparam logic SEL_BYTE = 1'b0;

  localparam int BOOT_N = 14;

  // Boot entry i as {byte address, byte value}.
  function automatic logic [15:0] boot_entry(input logic [3:0] i);
    case (i)
      4'd0:    boot_entry = {8'h00, 8'h3A};
      4'd1:    boot_entry = {8'h01, 8'hDC};
      4'd2:    boot_entry = {8'h02, 8'h00};
      4'd3:    boot_entry = {8'h03, 8'h00};
      4'd4:    boot_entry = {8'h04, 8'h13};
      4'd5:    boot_entry = {8'h05, 8'h42};
      4'd6:    boot_entry = {8'h06, 8'hAD};
      4'd7:    boot_entry = {8'h07, 8'hDE};
      4'd8:    boot_entry = {8'h08, 8'hEF};
      4'd9:    boot_entry = {8'h09, 8'hBE};
      4'd10:   boot_entry = {8'h0A, 8'hFF};
      4'd11:   boot_entry = {8'h0B, 8'hFF};
      4'd12:   boot_entry = {8'h0E, 8'hAA};
      4'd13:   boot_entry = {8'h0F, 8'hAA};
      default: boot_entry = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/datamem_init_seq.sv
// Power-on sequencer: clears every byte, then optionally writes the boot
// table, one byte per cycle, before handing the array to the user port.
module datamem_init_seq
  import datamem_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int INIT_EN = 1,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          busy,
  output logic          init_we,
  output logic [AW-1:0] init_addr,
  output logic [7:0]    init_data
);

  logic [1:0]    state;
  logic [AW-1:0] ptr;
  logic [15:0]   ent;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      case (state)
        ST_CLEAR:
          if (ptr == AW'(DEPTH-1)) begin
            state <= (INIT_EN != 0) ? ST_INIT : ST_IDLE;
            ptr   <= '0;
          end else ptr <= ptr + AW'(1);
        ST_INIT:
          if (ptr == AW'(BOOT_N-1)) begin
            state <= ST_IDLE;
            ptr   <= '0;
          end else ptr <= ptr + AW'(1);
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ent       = boot_entry(ptr[3:0]);
  assign busy      = (state != ST_IDLE);
  assign init_we   = (state == ST_CLEAR) || (state == ST_INIT);
  // Boot addresses are folded into the array by dropping the high bits.
  assign init_addr = (state == ST_INIT) ? AW'(ent[15:8]) : ptr;
  assign init_data = (state == ST_INIT) ? ent[7:0] : 8'h00;

endmodule

// File: rtl/datamem_param.sv
// Byte-addressed big-endian data memory with registered reads, optional
// alignment check and a sequenced clear/boot preload.
module datamem_param
  import datamem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 512,
  parameter int DATA_W    = 16,
  parameter int INIT_EN   = 1,
  parameter int ALIGN_CHK = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_n,
  input  logic              r_wr,
  input  logic              word_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              misalign_err
);

  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(DEPTH);

  logic [7:0]                mem [DEPTH];
  logic [AW-1:0]             idx;
  logic [NB-1:0][AW-1:0]     lane_addr;
  logic [NB-1:0][7:0]        lane_wd;
  logic [DATA_W-1:0]         rword, rbyte;
  logic                      init_we, req, misal;
  logic [AW-1:0]             init_addr;
  logic [7:0]                init_data;

  datamem_init_seq #(.DEPTH(DEPTH), .INIT_EN(INIT_EN), .AW(AW)) u_seq (
    .clk       (clk),
    .reset     (reset),
    .busy      (busy),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  assign idx   = addr[AW-1:0];
  assign req   = reset && !busy && !en_n;
  assign misal = (ALIGN_CHK != 0) && (word_sel == SEL_WORD) &&
                 ((addr % ADDR_W'(NB)) != '0);

  // Lane b holds word byte b counted from the MSB; addresses wrap in the array.
  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign lane_addr[b] = idx + AW'(b);
    assign lane_wd[b]   = wdata[DATA_W-1-8*b -: 8];
  end

  always_comb begin
    rword = '0;
    for (int b = 0; b < NB; b++) rword[DATA_W-1-8*b -: 8] = mem[lane_addr[b]];
  end
  assign rbyte = {{(DATA_W-8){1'b0}}, mem[idx]};

  always_ff @(posedge clk) begin
    if (reset) begin
      if (init_we) mem[init_addr] <= init_data;
      else if (req && r_wr == RW_WRITE && !misal) begin
        if (word_sel == SEL_WORD)
          for (int b = 0; b < NB; b++) mem[lane_addr[b]] <= lane_wd[b];
        else
          mem[idx] <= wdata[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata        <= '0;
      rvalid       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      rvalid       <= req && (r_wr == RW_READ);
      misalign_err <= req && misal;
      if (req && r_wr == RW_READ)
        rdata <= misal ? '0 : ((word_sel == SEL_WORD) ? rword : rbyte);
    end
  end

endmodule

// File: tb/tb_datamem_param.sv
// Directed bench: three memory configurations (16-bit, 16-bit aligned-check,
// 32-bit) sharing one clock, reset and request bus with per-instance enables.
module tb_datamem_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  en_n = 3'b111;
  logic        r_wr = 1'b1;
  logic        word_sel = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;

  logic [15:0] rd0, rd1;
  logic [31:0] rd2;
  logic        rv0, rv1, rv2, bz0, bz1, bz2, me0, me1, me2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  datamem_param #(.ADDR_W(16), .DEPTH(512), .DATA_W(16), .INIT_EN(1), .ALIGN_CHK(0)) u0 (
    .clk(clk), .reset(reset), .en_n(en_n[0]), .r_wr(r_wr), .word_sel(word_sel),
    .addr(addr), .wdata(wdata[15:0]), .rdata(rd0), .rvalid(rv0), .busy(bz0),
    .misalign_err(me0));

  datamem_param #(.ADDR_W(16), .DEPTH(512), .DATA_W(16), .INIT_EN(1), .ALIGN_CHK(1)) u1 (
    .clk(clk), .reset(reset), .en_n(en_n[1]), .r_wr(r_wr), .word_sel(word_sel),
    .addr(addr), .wdata(wdata[15:0]), .rdata(rd1), .rvalid(rv1), .busy(bz1),
    .misalign_err(me1));

  datamem_param #(.ADDR_W(16), .DEPTH(512), .DATA_W(32), .INIT_EN(1), .ALIGN_CHK(0)) u2 (
    .clk(clk), .reset(reset), .en_n(en_n[2]), .r_wr(r_wr), .word_sel(word_sel),
    .addr(addr), .wdata(wdata), .rdata(rd2), .rvalid(rv2), .busy(bz2),
    .misalign_err(me2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request on instance d, sampled on the next edge; outputs valid at return.
  task automatic acc(input int d, input logic rw, input logic ws,
                     input logic [15:0] a, input logic [31:0] wd);
    r_wr = rw; word_sel = ws; addr = a; wdata = wd;
    en_n[d] = 1'b0;
    @(posedge clk); #1;
    en_n = 3'b111;
  endtask

  initial begin
    int  n;
    logic rvseen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bz0), 64'h1);
    chk("rst_rdata", 64'(rd0), 64'h0);
    chk("rst_rvalid", 64'(rv0), 64'h0);
    chk("rst_misalign", 64'(me0), 64'h0);
    chk("rst_rdata32", 64'(rd2), 64'h0);

    // Run 100 cycles into the clear, poke a read, then restart the sequence
    reset = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("clear_busy", 64'(bz0), 64'h1);
    acc(0, 1'b1, 1'b1, 16'h0000, 32'h0);
    chk("busy_read_rvalid", 64'(rv0), 64'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Count busy cycles while hammering the port with reads/writes to 0x30
    n = 0; rvseen = 1'b0;
    addr = 16'h0030; word_sel = 1'b1; wdata = 32'h0000A5A5;
    en_n[0] = 1'b0;
    while (bz0 && n < 2000) begin
      r_wr = n[0];
      @(posedge clk); #1;
      n++;
      if (rv0) rvseen = 1'b1;
    end
    en_n = 3'b111;
    chk("busy_len", 64'(n), 64'd526);
    chk("busy_no_rvalid", 64'(rvseen), 64'h0);
    chk("busy1_done", 64'(bz1), 64'h0);
    chk("busy2_done", 64'(bz2), 64'h0);

    // Boot contents
    acc(0, 1'b1, 1'b1, 16'h0000, 32'h0);
    chk("boot_w0", 64'(rd0), 64'h3ADC);
    chk("boot_w0_rvalid", 64'(rv0), 64'h1);
    @(posedge clk); #1;
    chk("rvalid_pulse", 64'(rv0), 64'h0);
    chk("rdata_hold", 64'(rd0), 64'h3ADC);
    acc(0, 1'b1, 1'b1, 16'h000C, 32'h0);
    chk("boot_w0c", 64'(rd0), 64'h0000);
    acc(0, 1'b1, 1'b1, 16'h0030, 32'h0);
    chk("busy_write_blocked", 64'(rd0), 64'h0000);

    // Mixed byte/word, back-to-back
    acc(0, 1'b0, 1'b1, 16'h0020, 32'h0000BEEF);
    acc(0, 1'b1, 1'b0, 16'h0021, 32'h0);
    chk("byte_21", 64'(rd0), 64'h00EF);
    acc(0, 1'b0, 1'b0, 16'h0020, 32'h00000055);
    acc(0, 1'b1, 1'b1, 16'h0020, 32'h0);
    chk("word_20_b2b", 64'(rd0), 64'h55EF);

    // Wrap at the top of the array and address aliasing
    acc(0, 1'b0, 1'b1, 16'h01FF, 32'h00001234);
    acc(0, 1'b1, 1'b0, 16'h01FF, 32'h0);
    chk("wrap_1ff", 64'(rd0), 64'h0012);
    acc(0, 1'b1, 1'b0, 16'h0000, 32'h0);
    chk("wrap_000", 64'(rd0), 64'h0034);
    acc(0, 1'b1, 1'b0, 16'h0200, 32'h0);
    chk("alias_200", 64'(rd0), 64'h0034);
    acc(0, 1'b1, 1'b1, 16'hFFFF, 32'h0);
    chk("alias_ffff_word", 64'(rd0), 64'h1234);

    // Alignment check instance
    acc(1, 1'b0, 1'b1, 16'h0005, 32'h0000FFFF);
    chk("mis_wr_err", 64'(me1), 64'h1);
    chk("mis_wr_rvalid", 64'(rv1), 64'h0);
    acc(1, 1'b1, 1'b0, 16'h0005, 32'h0);
    chk("mis_byte_05", 64'(rd1), 64'h0042);
    chk("mis_byte_err", 64'(me1), 64'h0);
    acc(1, 1'b1, 1'b1, 16'h0005, 32'h0);
    chk("mis_rd_rdata", 64'(rd1), 64'h0000);
    chk("mis_rd_rvalid", 64'(rv1), 64'h1);
    chk("mis_rd_err", 64'(me1), 64'h1);
    acc(1, 1'b1, 1'b1, 16'h0004, 32'h0);
    chk("aligned_w04", 64'(rd1), 64'h1342);
    chk("aligned_err", 64'(me1), 64'h0);

    // 32-bit instance
    acc(2, 1'b1, 1'b1, 16'h0004, 32'h0);
    chk("w32_04", 64'(rd2), 64'h1342ADDE);
    acc(2, 1'b1, 1'b0, 16'h0007, 32'h0);
    chk("w32_byte_07", 64'(rd2), 64'h000000DE);
    acc(2, 1'b1, 1'b1, 16'h000A, 32'h0);
    chk("w32_0a_unaligned", 64'(rd2), 64'hFFFF0000);
    acc(2, 1'b1, 1'b1, 16'h01FE, 32'h0);
    chk("w32_1fe_wrap", 64'(rd2), 64'h00003ADC);
    acc(2, 1'b0, 1'b1, 16'h0040, 32'h11223344);
    acc(2, 1'b1, 1'b0, 16'h0041, 32'h0);
    chk("w32_byte_41", 64'(rd2), 64'h00000022);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datamem_param.md
Name: datamem_param

Overview:
Parametrised byte-addressed data memory for the term-project CPU datapath. It is the successor to the fixed 128-byte, 8/16-bit data memory. It supports a configurable word width and depth, big-endian multi-byte words, and registered reads with a valid strobe. An optional alignment check is provided. A sequenced power-on clear followed by a boot-table preload replaces the old combinational reset loop.

Parameters:
ADDR_W, 16, width of the address port
DEPTH, 512, storage size in bytes; must be a power of 2 and at least 16
DATA_W, 16, word width in bits; a multiple of 8, 16..64; NB = DATA_W/8 bytes per word
INIT_EN, 1, 1 = load the boot table after the clear; 0 = clear only
ALIGN_CHK, 0, 1 = reject word accesses where addr mod NB != 0

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-low
en_n  in  1  access request, active-low; sampled on the rising edge
r_wr  in  1  1 = read, 0 = write
word_sel  in  1  1 = full NB-byte word, 0 = single byte
addr  in  ADDR_W  byte address
wdata  in  DATA_W  write data; byte writes use wdata[7:0]
rdata  out  DATA_W  read data, registered; a byte read is zero-extended
rvalid  out  1  one-cycle pulse when rdata carries a new read result
busy  out  1  clear/preload sequence in progress
misalign_err  out  1  one-cycle pulse on a rejected misaligned access

Behaviour:
- Reset (reset=0 at a clk edge):
  - state <= CLEAR, ptr <= 0.
  - busy=1, rdata=0, rvalid=0, misalign_err=0.
  - Storage is not modified while reset is held low.
- FSM states: CLEAR, INIT, IDLE.
  - CLEAR: writes byte[ptr] <= 0 and increments ptr each cycle. After ptr = DEPTH-1 it goes to INIT if INIT_EN=1, else to IDLE. ptr resets to 0 on exit.
  - INIT: writes one boot-table entry per cycle, with address taken mod DEPTH. After entry BOOT_N-1 it goes to IDLE.
  - IDLE: busy=0; requests are served. IDLE is left only by reset.
- busy falls DEPTH (+BOOT_N if INIT_EN) cycles after the first edge with reset=1.
- Reset asserted in any state restarts the full sequence. The partial clear is not resumed.
- While busy=1, requests (en_n=0) are ignored: no write, no rvalid, no misalign_err.
- Addressing:
  - Index = addr mod DEPTH.
  - Word bytes occupy index, index+1, ..., index+NB-1, each taken mod DEPTH (wrap to 0).
  - Big-endian: the MSB of the word is at the lowest address.
- Write (IDLE, en_n=0, r_wr=0), committed on the same edge:
  - byte access: byte[index] <= wdata[7:0]
  - word access: NB bytes are written.
- Read (IDLE, en_n=0, r_wr=1):
  - rdata and rvalid update on the sampling edge, so the result is visible for the following cycle (1-cycle latency).
  - rvalid then returns to 0 unless another read is sampled.
  - rdata holds its last value between reads.
- Back-to-back: a read sampled on the edge after a write to the same address returns the new data. Throughput is one access per cycle with a single port.
- ALIGN_CHK=1 and word_sel=1 and addr mod NB != 0:
  - No write occurs.
  - A read returns rdata=0 with rvalid=1.
  - misalign_err pulses for 1 cycle.
  - Byte accesses are never misaligned.
- ALIGN_CHK=0: misaligned word accesses are permitted, with wrap as above.
- Address bits above log2(DEPTH) are ignored, so addresses alias.

Decomposition:
- Package datamem_pkg:
  - state enum {CLEAR, INIT, IDLE}
  - BOOT_N = 14
  - boot table (addr, byte): 00:3A 01:DC 02:00 03:00 04:13 05:42 06:AD 07:DE 08:EF 09:BE 0A:FF 0B:FF 0E:AA 0F:AA
  - word_sel and r_wr encoding constants
- One sub-module, datamem_init_seq, holds the FSM and ptr. It outputs busy, an init write enable, the init address and the init data. The top level muxes the init port and the user port onto the byte array.

Test Plan:
1. Power-on sequence: reset=0 for 2 cycles then release (DEPTH=512, INIT_EN=1).
   - busy stays high for exactly 526 cycles.
   - Word read at 0x0000 -> rdata=16'h3ADC with rvalid on the next cycle.
   - Word read at 0x000C -> 16'h0000.
2. Mixed byte/word access: word write 16'hBEEF at 0x0020.
   - Byte read at 0x0021 -> 16'h00EF.
   - Byte write 8'h55 at 0x0020, then word read at 0x0020 -> 16'h55EF.
   - Back-to-back write-then-read timing is exercised.
3. Wrap and alias (ALIGN_CHK=0): word write 16'h1234 at 0x01FF.
   - Byte 0x1FF reads 8'h12; byte 0x000 reads 8'h34.
   - Byte read at 0x0200 also returns 8'h34.
4. Alignment check (ALIGN_CHK=1): word write 16'hFFFF at 0x0005.
   - misalign_err pulses and byte 0x0005 still reads 8'h42.
   - Word read at 0x0005 -> rdata=0, rvalid=1, misalign_err=1.
5. Reset mid-clear: assert reset at cycle 100 of CLEAR.
   - busy restarts the full 526-cycle count.
   - Reads and writes issued while busy produce no rvalid and no change to storage.
6. Wider word (DATA_W=32): word read at 0x0004 -> 32'h1342ADDE.
   - Byte read at 0x0007 -> 32'h000000DE.
